// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshake signals and the single memory port.
// The slave modport is the arbiter side; master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH-1:0]        req_we;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH*3-1:0]      req_funct3;
  logic [NUM_CH-1:0]        resp_valid;
  logic [DATA_W-1:0]        resp_rdata;
  logic                     mem_en;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [2:0]               mem_funct3;
  logic [DATA_W-1:0]        mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_funct3
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_funct3
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates NUM_CH requesters onto one single-port memory, one transaction in flight.
// state | meaning: IDLE grant/accept | ISSUE mem_en strobe | WAIT count latency | RESP resp_valid pulse
module mem_port_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1,
  parameter int RR_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic               owner_we;
  logic [CNT_W-1:0]   wait_cnt;

  logic [NUM_CH-1:0]  grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               found;
  logic [IDX_W:0]     scan_idx;
  logic               accept;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan_idx  = '0;
    if (RR_MODE == 0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && bus.req_valid[i]) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = IDX_W'(i);
        end
      end
    end else begin
      // scan starts one past the last winner and wraps modulo NUM_CH
      for (int k = 1; k <= NUM_CH; k++) begin
        scan_idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
        if (scan_idx >= (IDX_W+1)'(NUM_CH))
          scan_idx = scan_idx - (IDX_W+1)'(NUM_CH);
        if (!found && bus.req_valid[scan_idx[IDX_W-1:0]]) begin
          found                          = 1'b1;
          grant[scan_idx[IDX_W-1:0]]     = 1'b1;
          grant_idx                      = scan_idx[IDX_W-1:0];
        end
      end
    end
  end

  assign bus.req_ready = (rst && state == IDLE) ? grant : '0;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      rr_ptr         <= IDX_W'(NUM_CH - 1);
      owner          <= '0;
      owner_we       <= 1'b0;
      wait_cnt       <= '0;
      bus.resp_valid <= '0;
      bus.resp_rdata <= '0;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.mem_funct3 <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.resp_valid <= '0;
          if (accept) begin
            state          <= ISSUE;
            owner          <= grant_idx;
            owner_we       <= bus.req_we[grant_idx];
            bus.mem_en     <= 1'b1;
            bus.mem_we     <= bus.req_we[grant_idx];
            bus.mem_addr   <= bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            bus.mem_wdata  <= bus.req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
            bus.mem_funct3 <= bus.req_funct3[int'(grant_idx)*3 +: 3];
            if (RR_MODE != 0)
              rr_ptr <= grant_idx;
          end
        end
        ISSUE: begin
          bus.mem_en     <= 1'b0;
          bus.mem_we     <= 1'b0;
          bus.mem_addr   <= '0;
          bus.mem_wdata  <= '0;
          bus.mem_funct3 <= '0;
          wait_cnt       <= CNT_W'(1);
          state          <= WAIT;
        end
        WAIT: begin
          // mem_rdata is only trusted on the cycle the latency count is reached
          if (wait_cnt == CNT_W'(MEM_LAT)) begin
            bus.resp_rdata <= owner_we ? '0 : bus.mem_rdata;
            bus.resp_valid <= NUM_CH'(1) << owner;
            wait_cnt       <= '0;
            state          <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          bus.resp_valid <= '0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: three arbiter configurations (fixed/lat1, RR NUM_CH=3, fixed/lat4).
// Stimulus pushes expected mem strobes and responses; a negedge monitor pops and compares.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic mon_on = 1'b0;

  logic [2:0][2:0]  rv, rwe;
  logic [2:0][47:0] ra;
  logic [2:0][95:0] rwd;
  logic [2:0][8:0]  rf3;

  logic [2:0][2:0]  rdy, rsp_v, mf3;
  logic [2:0][31:0] rsp_d, mwd;
  logic [2:0][15:0] maddr;
  logic [2:0]       men, mwe, busy;

  typedef struct {int d; int ch; logic [31:0] data; int cy;} resp_t;
  typedef struct {int d; logic we; logic [15:0] addr; logic [31:0] wd; logic [2:0] f3; int cy;} memev_t;
  resp_t  rq[$];
  memev_t mq[$];

  function automatic logic [31:0] mem_word(logic [15:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {a, ~a};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int NC  = (g == 0) ? 2 : 3;
    localparam int LAT = (g == 2) ? 4 : 1;
    localparam int RR  = (g == 1) ? 1 : 0;
    mem_port_arbiter_if #(.NUM_CH(NC), .ADDR_W(16), .DATA_W(32)) bus ();
    mem_port_arbiter #(.NUM_CH(NC), .ADDR_W(16), .DATA_W(32), .MEM_LAT(LAT), .RR_MODE(RR)) dut (
      .clk(clk), .rst(rst), .bus(bus), .busy(busy[g])
    );
    assign bus.req_valid  = rv[g][NC-1:0];
    assign bus.req_we     = rwe[g][NC-1:0];
    assign bus.req_addr   = ra[g][NC*16-1:0];
    assign bus.req_wdata  = rwd[g][NC*32-1:0];
    assign bus.req_funct3 = rf3[g][NC*3-1:0];
    assign rdy[g]   = 3'(bus.req_ready);
    assign rsp_v[g] = 3'(bus.resp_valid);
    assign rsp_d[g] = bus.resp_rdata;
    assign men[g]   = bus.mem_en;
    assign mwe[g]   = bus.mem_we;
    assign maddr[g] = bus.mem_addr;
    assign mwd[g]   = bus.mem_wdata;
    assign mf3[g]   = bus.mem_funct3;

    // memory model: data valid exactly LAT cycles after the strobe, garbage otherwise
    logic [2:0]  cd = '0;
    logic [15:0] ma = '0;
    always @(posedge clk) begin
      if (bus.mem_en && !bus.mem_we) begin
        cd <= 3'(LAT);
        ma <= bus.mem_addr;
      end else if (cd != 3'd0) begin
        cd <= cd - 3'd1;
      end
    end
    assign bus.mem_rdata = (cd == 3'd1) ? mem_word(ma) : {16'hBAD0, 16'(cyc)};
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(int d, int ch, logic v, logic we, logic [15:0] a, logic [31:0] wd, logic [2:0] f3);
    rv[d][ch]            = v;
    rwe[d][ch]           = we;
    ra[d][ch*16 +: 16]   = a;
    rwd[d][ch*32 +: 32]  = wd;
    rf3[d][ch*3 +: 3]    = f3;
  endtask

  task automatic exp_resp(int d, int ch, logic [31:0] data, int cy);
    resp_t e;
    e.d = d; e.ch = ch; e.data = data; e.cy = cy;
    rq.push_back(e);
  endtask

  task automatic exp_mem(int d, logic we, logic [15:0] a, logic [31:0] wd, logic [2:0] f3, int cy);
    memev_t e;
    e.d = d; e.we = we; e.addr = a; e.wd = wd; e.f3 = f3; e.cy = cy;
    mq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      for (int d = 0; d < 3; d++) begin
        check("ready_onehot", 32'($onehot0(rdy[d])), 32'd1);
        if (rsp_v[d] != 3'b000) begin
          if (rq.size() == 0) begin
            total++; bad++;
            $display("FAIL resp_unexpected @cyc %0d: dut %0d got valid %b want none", cyc, d, rsp_v[d]);
          end else begin
            resp_t e;
            e = rq.pop_front();
            check("resp_dut",   32'(d), 32'(e.d));
            check("resp_chan",  32'(rsp_v[d]), 32'(1 << e.ch));
            check("resp_data",  rsp_d[d], e.data);
            check("resp_cycle", 32'(cyc), 32'(e.cy));
          end
        end
        if (men[d]) begin
          if (mq.size() == 0) begin
            total++; bad++;
            $display("FAIL mem_unexpected @cyc %0d: dut %0d got mem_en 1 want 0", cyc, d);
          end else begin
            memev_t m;
            m = mq.pop_front();
            check("mem_dut",   32'(d), 32'(m.d));
            check("mem_we",    32'(mwe[d]), 32'(m.we));
            check("mem_addr",  32'(maddr[d]), 32'(m.addr));
            check("mem_wdata", mwd[d], m.wd);
            check("mem_funct3", 32'(mf3[d]), 32'(m.f3));
            check("mem_cycle", 32'(cyc), 32'(m.cy));
          end
        end else begin
          check("mem_idle_quiet", 32'(mwe[d] | (|maddr[d]) | (|mwd[d]) | (|mf3[d])), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int rr_ch[4];
    logic [31:0] rr_data[4];
    logic [15:0] rr_addr[3];
    logic [31:0] rr_wd[3];
    logic [2:0]  rr_f3[3];
    logic        rr_we[3];

    rst = 1'b0; rv = '0; rwe = '0; ra = '0; rwd = '0; rf3 = '0;
    repeat (3) tick();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_ready",  32'(rdy[d]),   32'd0);
      check("rst_resp_v", 32'(rsp_v[d]), 32'd0);
      check("rst_resp_d", rsp_d[d],      32'd0);
      check("rst_mem_en", 32'(men[d]),   32'd0);
      check("rst_busy",   32'(busy[d]),  32'd0);
    end
    tick(); rst = 1'b1; mon_on = 1'b1;
    tick(); tick();

    // single load on ch1, lat 1
    c = cyc;
    set_ch(0, 1, 1'b1, 1'b0, 16'h0010, 32'h11111111, 3'b010);
    exp_mem(0, 1'b0, 16'h0010, 32'h11111111, 3'b010, c + 1);
    exp_resp(0, 1, 32'hDEADBEEF, c + 3);
    @(negedge clk);
    check("t1_ready", 32'(rdy[0]), 32'b010);
    check("t1_busy0", 32'(busy[0]), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) rv[0] = '0;
      @(negedge clk);
      check("t1_busy", 32'(busy[0]), (k < 4) ? 32'd1 : 32'd0);
    end

    // store on ch0: response data must be zero
    tick();
    c = cyc;
    set_ch(0, 0, 1'b1, 1'b1, 16'h0004, 32'h12345678, 3'b010);
    exp_mem(0, 1'b1, 16'h0004, 32'h12345678, 3'b010, c + 1);
    exp_resp(0, 0, 32'h0, c + 3);
    @(negedge clk);
    check("t2_ready", 32'(rdy[0]), 32'b001);
    tick(); rv[0] = '0;
    repeat (4) tick();

    // fixed priority: ch0 and ch1 both held, ch0 wins three times
    c = cyc;
    set_ch(0, 0, 1'b1, 1'b0, 16'h0040, 32'h000000AA, 3'b100);
    set_ch(0, 1, 1'b1, 1'b0, 16'h0050, 32'h000000BB, 3'b100);
    for (int k = 0; k < 3; k++) begin
      exp_mem(0, 1'b0, 16'h0040, 32'h000000AA, 3'b100, c + 1 + 4*k);
      exp_resp(0, 0, 32'h0040FFBF, c + 3 + 4*k);
    end
    repeat (9) tick();
    rv[0] = '0;
    repeat (6) tick();

    // round-robin over three channels: 0,1,2 then wrap to 0
    c = cyc;
    rr_addr = '{16'h0100, 16'h0200, 16'h0300};
    rr_wd   = '{32'h00000001, 32'hA5A5A5A5, 32'h00000003};
    rr_f3   = '{3'b000, 3'b010, 3'b101};
    rr_we   = '{1'b0, 1'b1, 1'b0};
    rr_ch   = '{0, 1, 2, 0};
    rr_data = '{32'h0100FEFF, 32'h00000000, 32'h0300FCFF, 32'h0100FEFF};
    for (int ch = 0; ch < 3; ch++)
      set_ch(1, ch, 1'b1, rr_we[ch], rr_addr[ch], rr_wd[ch], rr_f3[ch]);
    for (int k = 0; k < 4; k++) begin
      exp_mem(1, rr_we[rr_ch[k]], rr_addr[rr_ch[k]], rr_wd[rr_ch[k]], rr_f3[rr_ch[k]], c + 1 + 4*k);
      exp_resp(1, rr_ch[k], rr_data[k], c + 3 + 4*k);
    end
    repeat (13) tick();
    rv[1] = '0;
    repeat (6) tick();

    // latency 4: response at accept+6, next accept at accept+7
    c = cyc;
    set_ch(2, 1, 1'b1, 1'b0, 16'h0020, 32'h00000022, 3'b010);
    exp_mem(2, 1'b0, 16'h0020, 32'h00000022, 3'b010, c + 1);
    exp_resp(2, 1, 32'h0020FFDF, c + 6);
    @(negedge clk);
    check("t5_ready_first", 32'(rdy[2]), 32'b010);
    tick();
    rv[2][1] = 1'b0;
    set_ch(2, 0, 1'b1, 1'b0, 16'h0030, 32'h00000033, 3'b001);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) tick();
      @(negedge clk);
      check("t5_ready_blocked", 32'(rdy[2]), 32'b000);
    end
    tick();
    @(negedge clk);
    check("t5_ready_next", 32'(rdy[2]), 32'b001);
    exp_mem(2, 1'b0, 16'h0030, 32'h00000033, 3'b001, c + 8);
    exp_resp(2, 0, 32'h0030FFCF, c + 13);
    tick();
    rv[2] = '0;
    repeat (7) tick();

    // reset during WAIT abandons the transaction
    c = cyc;
    set_ch(2, 0, 1'b1, 1'b0, 16'h0060, 32'h00000066, 3'b010);
    exp_mem(2, 1'b0, 16'h0060, 32'h00000066, 3'b010, c + 1);
    tick(); rv[2] = '0;
    tick();
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
    @(negedge clk);
    check("t6_busy",   32'(busy[2]),  32'd0);
    check("t6_mem_en", 32'(men[2]),   32'd0);
    check("t6_resp_v", 32'(rsp_v[2]), 32'd0);
    check("t6_resp_d", rsp_d[2],      32'd0);
    repeat (8) tick();

    // recovery after the abort
    c = cyc;
    set_ch(2, 1, 1'b1, 1'b0, 16'h0070, 32'h00000077, 3'b010);
    exp_mem(2, 1'b0, 16'h0070, 32'h00000077, 3'b010, c + 1);
    exp_resp(2, 1, 32'h0070FF8F, c + 6);
    tick(); rv[2] = '0;
    repeat (8) tick();

    @(negedge clk);
    check("resp_queue_empty", 32'(rq.size()), 32'd0);
    check("mem_queue_empty",  32'(mq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates N requesters (instruction fetch, data load/store, future DMA/debug) onto one single-port unified instruction/data memory.
- Replaces clock-level address-mux tricks with a clean valid/ready handshake, configurable fixed or round-robin priority, and a parametrised memory read latency.
- Sits between the pipeline's IF/MEM stages and the memory. Holds one transaction in flight; the pipeline stalls on req_ready=0.

Parameters:
- NUM_CH, 2, number of requester channels (>=2); channel 0 = instruction fetch.
- ADDR_W, 16, memory address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from mem_en asserted to mem_rdata valid (>=1).
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel accept; at most one bit high.
- req_we  in  NUM_CH  1 = store, 0 = load.
- req_addr  in  NUM_CH*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_CH*DATA_W  packed store data.
- req_funct3  in  NUM_CH*3  packed access size/sign code, passed to memory.
- resp_valid  out  NUM_CH  one-cycle completion pulse for the owning channel.
- resp_rdata  out  DATA_W  load data, shared; meaningful only with resp_valid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_funct3  out  3  memory access size code.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state = IDLE; all outputs = 0; latched request = 0; wait counter = 0.
  - RR pointer = NUM_CH-1, so the first round-robin grant searches from channel 0.
  - Reset mid-transaction abandons it: no resp_valid is issued, and memory is not driven afterwards.
- States:
  - IDLE → ISSUE on accept.
  - ISSUE → WAIT.
  - WAIT → RESP when the counter reaches MEM_LAT.
  - RESP → IDLE.
- IDLE:
  - req_ready is combinational and one-hot: the winner among req_valid under the selected policy. All zeros if no request.
  - Accept = req_valid[g] & req_ready[g]. Latch g, we, addr, wdata, funct3.
  - For RR_MODE=1, update the RR pointer to g.
- Priority:
  - Fixed: lowest set index wins.
  - Round-robin: first set index scanning ptr+1, ptr+2, … modulo NUM_CH; the scan wraps from NUM_CH-1 to 0.
- ISSUE (cycle T+1 after accept at T):
  - mem_en=1 for exactly this cycle, with mem_we/addr/wdata/funct3 from the latch.
  - The counter loads 1.
- WAIT: the counter increments each cycle. On the cycle the counter == MEM_LAT, capture mem_rdata into resp_rdata (loads), or 0 (stores).
- RESP (cycle T+MEM_LAT+2): resp_valid[g]=1 for one cycle; req_ready all 0.
- Next request is accepted in IDLE at T+MEM_LAT+3 at the earliest. Throughput is 1 transaction per MEM_LAT+3 cycles.
- req_ready is 0 in every non-IDLE state. A requester holds valid and payload until it sees ready; the arbiter samples the payload only on the accept cycle.
- mem_* outputs are 0 when mem_en=0.
- resp_rdata holds its last value until the next capture.
- Simultaneous requests: exactly one is granted per IDLE cycle; losers keep req_ready=0 and retry.
- A channel deasserting req_valid before it is accepted is legal and causes no state change.
- No back-pressure on the response: resp_valid is a pulse, and the owner must take it.

Test Plan:
- Reset then single load: ch1 valid, addr=0x0010, we=0, MEM_LAT=1, mem returns 0xDEADBEEF.
  - req_ready[1] is high the same cycle.
  - mem_en with addr 0x0010 one cycle later.
  - resp_valid[1] with 0xDEADBEEF at accept+3.
  - busy high for 3 cycles.
- Store: ch0 we=1, addr=0x0004, wdata=0x12345678.
  - mem_en=mem_we=1 with those values for exactly 1 cycle.
  - resp_valid[0] pulses with resp_rdata=0.
- Fixed priority (RR_MODE=0): ch0 and ch1 both valid continuously for 3 transactions → all 3 grants go to ch0; ch1 starves.
- Round-robin (RR_MODE=1, NUM_CH=3): all three channels valid continuously → grant order 0,1,2,0; the wrap from 2 to 0 is verified.
- Latency sweep: MEM_LAT=4 → resp_valid at accept+6; next req_ready is not before accept+7. mem_rdata sampled only on the counter==4 cycle; garbage on other cycles is ignored.
- Reset mid-op: rst=0 during WAIT → next cycle state IDLE, all outputs 0, and no resp_valid ever issued for the aborted transaction.
